rvx_ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one `rvx_ram` instance between two requesters, for example the instruction-fetch and data ports of the RVX core. It sits between the requesters and the RAM's single read/write port and forwards one request per cycle. It tracks which requester owns the single in-flight transaction and routes the RAM's one-cycle-later response back to that requester only.

---
 rtl/rvx_ram_arbiter_pkg.sv | 8 +
 rtl/rvx_rr_arbiter2.sv | 22 ++
 rtl/rvx_ram_arbiter.sv | 111 +++++++++++
 tb/tb_rvx_ram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvx_ram_arbiter_pkg.sv
// Shared widths for the RVX RAM arbiter slice.
package rvx_ram_arbiter_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

endpackage

// File: rtl/rvx_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone eligible requester wins,
// a tie goes to the requester that did not win last time.
module rvx_rr_arbiter2 (
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       granted
);

    // Pick the winner from the eligible set and the previous winner.
    always_comb begin
        grant_valid = |elig;
        granted     = 1'b0;
        case (elig)
            2'b01:   granted = 1'b0;
            2'b10:   granted = 1'b1;
            2'b11:   granted = ~last_grant;
            default: granted = 1'b0;
        endcase
    end

endmodule

// File: rtl/rvx_ram_arbiter.sv
// Shares one rvx_ram port between two requesters. One transaction is forwarded
// per cycle; the RAM's next-cycle response is routed back to its owner only.
module rvx_ram_arbiter
    import rvx_ram_arbiter_pkg::*;
#(
    parameter logic RESET_PRIORITY = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic [AddrWidth-1:0] m0_rw_address,
    output logic [DataWidth-1:0] m0_read_data,
    input  logic                 m0_read_request,
    output logic                 m0_read_response,
    input  logic [DataWidth-1:0] m0_write_data,
    input  logic [StrbWidth-1:0] m0_write_strobe,
    input  logic                 m0_write_request,
    output logic                 m0_write_response,

    input  logic [AddrWidth-1:0] m1_rw_address,
    output logic [DataWidth-1:0] m1_read_data,
    input  logic                 m1_read_request,
    output logic                 m1_read_response,
    input  logic [DataWidth-1:0] m1_write_data,
    input  logic [StrbWidth-1:0] m1_write_strobe,
    input  logic                 m1_write_request,
    output logic                 m1_write_response,

    output logic [AddrWidth-1:0] ram_rw_address,
    input  logic [DataWidth-1:0] ram_read_data,
    output logic                 ram_read_request,
    input  logic                 ram_read_response,
    output logic [DataWidth-1:0] ram_write_data,
    output logic [StrbWidth-1:0] ram_write_strobe,
    output logic                 ram_write_request,
    input  logic                 ram_write_response
);

    logic       pending_q, owner_q, last_grant_q;
    logic [1:0] elig;
    logic       grant_valid, granted;
    logic       resp_to0, resp_to1;

    // Eligibility: a requester whose transaction is completing this cycle is
    // blocked so its still-high request is not re-forwarded. Nothing is
    // forwarded while reset is held.
    always_comb begin
        elig[0] = (m0_read_request | m0_write_request) & ~(pending_q & ~owner_q) & ~reset;
        elig[1] = (m1_read_request | m1_write_request) & ~(pending_q & owner_q) & ~reset;
    end

    rvx_rr_arbiter2 u_pick (
        .elig        (elig),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .granted     (granted)
    );

    // Forward the granted requester's fields to the RAM; all zero when idle.
    always_comb begin
        ram_rw_address    = '0;
        ram_read_request  = 1'b0;
        ram_write_data    = '0;
        ram_write_strobe  = '0;
        ram_write_request = 1'b0;
        if (grant_valid) begin
            if (granted) begin
                ram_rw_address    = m1_rw_address;
                ram_read_request  = m1_read_request;
                ram_write_data    = m1_write_data;
                ram_write_strobe  = m1_write_strobe;
                ram_write_request = m1_write_request;
            end else begin
                ram_rw_address    = m0_rw_address;
                ram_read_request  = m0_read_request;
                ram_write_data    = m0_write_data;
                ram_write_strobe  = m0_write_strobe;
                ram_write_request = m0_write_request;
            end
        end
    end

    // In-flight tracking and round-robin history.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q    <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= ~RESET_PRIORITY;
        end else begin
            pending_q <= grant_valid;
            if (grant_valid) begin
                owner_q      <= granted;
                last_grant_q <= granted;
            end
        end
    end

    // Route RAM responses to the owner of the in-flight transaction only;
    // responses with nothing in flight, or during reset, are dropped.
    always_comb begin
        resp_to0          = pending_q & ~owner_q & ~reset;
        resp_to1          = pending_q & owner_q & ~reset;
        m0_read_response  = ram_read_response & resp_to0;
        m0_write_response = ram_write_response & resp_to0;
        m1_read_response  = ram_read_response & resp_to1;
        m1_write_response = ram_write_response & resp_to1;
        m0_read_data      = m0_read_response ? ram_read_data : '0;
        m1_read_data      = m1_read_response ? ram_read_data : '0;
    end

endmodule

// File: tb/tb_rvx_ram_arbiter.sv
// Self-checking bench for rvx_ram_arbiter with a one-cycle RAM model and a
// response scoreboard.
module tb_rvx_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] m0_rw_address = '0, m0_write_data = '0, m0_read_data;
    logic [3:0]  m0_write_strobe = '0;
    logic        m0_read_request = 1'b0, m0_write_request = 1'b0;
    logic        m0_read_response, m0_write_response;

    logic [31:0] m1_rw_address = '0, m1_write_data = '0, m1_read_data;
    logic [3:0]  m1_write_strobe = '0;
    logic        m1_read_request = 1'b0, m1_write_request = 1'b0;
    logic        m1_read_response, m1_write_response;

    logic [31:0] ram_rw_address, ram_read_data, ram_write_data;
    logic [3:0]  ram_write_strobe;
    logic        ram_read_request, ram_read_response, ram_write_request, ram_write_response;

    // RAM model state plus stray-response injection.
    logic        m_rresp = 1'b0, m_wresp = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        stray_rd = 1'b0, stray_wr = 1'b0;
    logic [31:0] stray_data = '0;

    assign ram_read_response  = m_rresp | stray_rd;
    assign ram_write_response = m_wresp | stray_wr;
    assign ram_read_data      = stray_rd ? stray_data : m_rdata;

    int n_pass = 0;
    int n_total = 0;
    // Scoreboard entry: {r0, w0, r1, w1, m0_read_data, m1_read_data}
    logic [67:0] exp_q[$];

    always #5 clock = ~clock;

    rvx_ram_arbiter #(.RESET_PRIORITY(1'b0)) dut (
        .clock              (clock),
        .reset              (reset),
        .m0_rw_address      (m0_rw_address),
        .m0_read_data       (m0_read_data),
        .m0_read_request    (m0_read_request),
        .m0_read_response   (m0_read_response),
        .m0_write_data      (m0_write_data),
        .m0_write_strobe    (m0_write_strobe),
        .m0_write_request   (m0_write_request),
        .m0_write_response  (m0_write_response),
        .m1_rw_address      (m1_rw_address),
        .m1_read_data       (m1_read_data),
        .m1_read_request    (m1_read_request),
        .m1_read_response   (m1_read_response),
        .m1_write_data      (m1_write_data),
        .m1_write_strobe    (m1_write_strobe),
        .m1_write_request   (m1_write_request),
        .m1_write_response  (m1_write_response),
        .ram_rw_address     (ram_rw_address),
        .ram_read_data      (ram_read_data),
        .ram_read_request   (ram_read_request),
        .ram_read_response  (ram_read_response),
        .ram_write_data     (ram_write_data),
        .ram_write_strobe   (ram_write_strobe),
        .ram_write_request  (ram_write_request),
        .ram_write_response (ram_write_response)
    );

    // RAM model: 64 words, one-cycle latency, read returns old data,
    // out-of-range addresses read 0. Inputs captured mid-cycle to avoid races.
    initial begin : ram_model
        logic [31:0] mem [0:63];
        logic [31:0] a, wd;
        logic [3:0]  ws;
        logic        rr, wr;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h5555AAAA;
        forever begin
            @(negedge clock);
            a = ram_rw_address; wd = ram_write_data; ws = ram_write_strobe;
            rr = ram_read_request; wr = ram_write_request;
            @(posedge clock);
            m_rresp <= rr;
            m_wresp <= wr;
            if (rr) m_rdata <= (a < 32'd256) ? mem[a[7:2]] : 32'h0;
            if (wr && a < 32'd256) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
            end
        end
    end

    // Response monitor: every response pops the scoreboard; read data must be
    // 0 whenever its response is low.
    initial begin : monitor
        logic [67:0] obs, e;
        forever begin
            @(negedge clock);
            obs = {m0_read_response, m0_write_response, m1_read_response, m1_write_response,
                   m0_read_data, m1_read_data};
            if (obs[67:64] != 4'b0) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_response t=%0t got %h required none", $time, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("FAIL response t=%0t got %h required %h", $time, obs, e);
                    else n_pass++;
                end
            end
            n_total++;
            if ((!m0_read_response && m0_read_data !== 32'h0) ||
                (!m1_read_response && m1_read_data !== 32'h0))
                $display("FAIL idle_read_data t=%0t got %h/%h required 0/0", $time,
                         m0_read_data, m1_read_data);
            else n_pass++;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        m0_rw_address = 32'h10; m0_read_request = 1'b1;
        m1_rw_address = 32'h14; m1_read_request = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #2;
            n_total++;
            if ({ram_read_request, ram_write_request} !== 2'b00)
                $display("FAIL reset_ram_req got %b required 00", {ram_read_request, ram_write_request});
            else n_pass++;
            n_total++;
            if ({m0_read_response, m0_write_response, m1_read_response, m1_write_response} !== 4'b0)
                $display("FAIL reset_mx_resp got %b required 0000",
                         {m0_read_response, m0_write_response, m1_read_response, m1_write_response});
            else n_pass++;
        end
        #1 reset = 1'b0; #1;
        n_total++;
        if (ram_read_request !== 1'b1 || ram_rw_address !== 32'h10)
            $display("FAIL first_grant got req=%b addr=%h required 1/00000010",
                     ram_read_request, ram_rw_address);
        else n_pass++;
        exp_q.push_back({4'b1000, 32'hDEADBEEF, 32'h0});
        @(posedge clock); #2;
        n_total++;
        if (ram_read_request !== 1'b1 || ram_rw_address !== 32'h14)
            $display("FAIL second_grant got req=%b addr=%h required 1/00000014",
                     ram_read_request, ram_rw_address);
        else n_pass++;
        exp_q.push_back({4'b0010, 32'h0, 32'h5555AAAA});
        @(posedge clock); #1 m0_read_request = 1'b0; #1;
        n_total++;
        if (ram_read_request !== 1'b0) $display("FAIL reset_drain got %b required 0", ram_read_request);
        else n_pass++;
        @(posedge clock); #1 m1_read_request = 1'b0; #1;
    endtask

    task automatic test_single_reader();
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (i == 0) begin m0_rw_address = 32'h10; m0_read_request = 1'b1; end
            #1;
            n_total++;
            if (ram_read_request !== (i % 2 == 0))
                $display("FAIL single_rd_req cycle %0d got %b required %b", i, ram_read_request,
                         (i % 2 == 0));
            else n_pass++;
            if (i % 2 == 0) exp_q.push_back({4'b1000, 32'hDEADBEEF, 32'h0});
            else begin
                n_total++;
                if (m1_read_response !== 1'b0 || m1_read_data !== 32'h0)
                    $display("FAIL single_rd_m1 got %b/%h required 0/0", m1_read_response, m1_read_data);
                else n_pass++;
            end
        end
        @(posedge clock); #1 m0_read_request = 1'b0; #1;
        n_total++;
        if (ram_read_request !== 1'b0) $display("FAIL single_rd_idle got %b required 0", ram_read_request);
        else n_pass++;
    endtask

    // Last winner before this test is m0, so contention starts with m1.
    task automatic test_contention();
        logic g;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (i == 0) begin
                m0_rw_address = 32'h20; m0_write_data = 32'h11223344;
                m0_write_strobe = 4'hF; m0_write_request = 1'b1;
                m1_rw_address = 32'h20; m1_read_request = 1'b1;
            end
            #1;
            g = (i % 2 == 0);
            n_total++;
            if (ram_read_request !== g || ram_write_request !== !g || ram_rw_address !== 32'h20)
                $display("FAIL contention_grant cycle %0d got rd=%b wr=%b addr=%h required %b/%b/00000020",
                         i, ram_read_request, ram_write_request, ram_rw_address, g, !g);
            else n_pass++;
            if (g) exp_q.push_back({4'b0010, 32'h0, (i > 1) ? 32'h11223344 : 32'h0});
            else begin
                n_total++;
                if (ram_write_data !== 32'h11223344 || ram_write_strobe !== 4'hF)
                    $display("FAIL contention_wdata got %h/%h required 11223344/f",
                             ram_write_data, ram_write_strobe);
                else n_pass++;
                exp_q.push_back({4'b0100, 32'h0, 32'h0});
            end
        end
        @(posedge clock); #1 m1_read_request = 1'b0; #1;
        n_total++;
        if ({ram_read_request, ram_write_request} !== 2'b00)
            $display("FAIL contention_drain got %b required 00", {ram_read_request, ram_write_request});
        else n_pass++;
        @(posedge clock); #1 m0_write_request = 1'b0; m0_write_strobe = 4'h0;
    endtask

    task automatic test_byte_write();
        @(posedge clock); #1;
        m1_rw_address = 32'h40; m1_write_data = 32'h0000AB00;
        m1_write_strobe = 4'h2; m1_write_request = 1'b1;
        #1;
        n_total++;
        if (ram_write_request !== 1'b1 || ram_write_strobe !== 4'h2 ||
            ram_rw_address !== 32'h40 || ram_write_data !== 32'h0000AB00)
            $display("FAIL byte_wr_fwd got wr=%b strb=%h addr=%h data=%h required 1/2/00000040/0000ab00",
                     ram_write_request, ram_write_strobe, ram_rw_address, ram_write_data);
        else n_pass++;
        exp_q.push_back({4'b0001, 32'h0, 32'h0});
        @(posedge clock); #2;
        n_total++;
        if (ram_write_request !== 1'b0) $display("FAIL byte_wr_block got %b required 0", ram_write_request);
        else n_pass++;
        @(posedge clock); #1;
        m1_write_request = 1'b0; m1_write_strobe = 4'h0; m1_read_request = 1'b1;
        #1;
        n_total++;
        if (ram_read_request !== 1'b1 || ram_rw_address !== 32'h40)
            $display("FAIL byte_rd_fwd got %b/%h required 1/00000040", ram_read_request, ram_rw_address);
        else n_pass++;
        exp_q.push_back({4'b0010, 32'h0, 32'h0000AB00});
        @(posedge clock); #2;
        @(posedge clock); #1 m1_read_request = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(posedge clock); #1;
        m0_rw_address = 32'h10; m0_read_request = 1'b1;
        #1;
        n_total++;
        if (ram_read_request !== 1'b1) $display("FAIL mid_reset_grant got %b required 1", ram_read_request);
        else n_pass++;
        @(posedge clock); #1 reset = 1'b1; #1;
        n_total++;
        if (m0_read_response !== 1'b0 || m0_read_data !== 32'h0 || ram_read_request !== 1'b0)
            $display("FAIL mid_reset_drop got resp=%b data=%h req=%b required 0/0/0",
                     m0_read_response, m0_read_data, ram_read_request);
        else n_pass++;
        @(posedge clock); #1 reset = 1'b0; #1;
        n_total++;
        if (ram_read_request !== 1'b1 || ram_rw_address !== 32'h10)
            $display("FAIL mid_reset_reissue got %b/%h required 1/00000010",
                     ram_read_request, ram_rw_address);
        else n_pass++;
        exp_q.push_back({4'b1000, 32'hDEADBEEF, 32'h0});
        @(posedge clock); #2;
        @(posedge clock); #1 m0_read_request = 1'b0;
    endtask

    task automatic test_stray();
        @(posedge clock); #1;
        stray_rd = 1'b1; stray_wr = 1'b1; stray_data = 32'hCAFEF00D;
        #1;
        n_total++;
        if ({m0_read_response, m0_write_response, m1_read_response, m1_write_response} !== 4'b0 ||
            m0_read_data !== 32'h0 || m1_read_data !== 32'h0)
            $display("FAIL stray_resp got %b %h %h required 0000 0 0",
                     {m0_read_response, m0_write_response, m1_read_response, m1_write_response},
                     m0_read_data, m1_read_data);
        else n_pass++;
        @(posedge clock); #1 stray_rd = 1'b0; stray_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_reader();
        test_contention();
        test_byte_write();
        test_mid_reset();
        test_stray();
        repeat (2) @(posedge clock);
        #2;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL missing_responses got %0d pending required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
